// File: rtl/ahb_slave_ram.sv
// AHB slave with a DEPTH-word RAM, programmable wait states
// and a two-cycle ERROR response for illegal transfers.
module ahb_slave_ram #(
  parameter int BUS_WDT     = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic               i_hclk,
  input  logic               i_hreset_n,
  input  logic               i_hsel,
  input  logic [31:0]        i_haddr,
  input  logic [1:0]         i_htrans,
  input  logic [1:0]         i_hsize,
  input  logic [1:0]         i_hburst,
  input  logic               i_hwrite,
  input  logic [BUS_WDT-1:0] i_hwdata,
  input  logic               i_hready,
  output logic               o_hready,
  output logic [1:0]         o_hresp,
  output logic [BUS_WDT-1:0] o_hrdata
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WS_LD =
    4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [AW+1:0]     addr_q, addr_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic [BUS_WDT-1:0] mem_q [DEPTH];

  logic          acc;
  logic          bad;
  logic [3:0]    strb;
  logic          we;
  logic [AW-1:0] idx;
  logic          unused;

  assign unused = ^{i_hburst, i_htrans[0]};
  assign acc = i_hsel & i_hready & i_htrans[1];
  assign idx = addr_q[AW+1:2];

  assign bad = ((i_haddr >> (AW + 2)) != 32'd0)
             | (i_hsize == 2'd3)
             | ((i_hsize == 2'd1) & i_haddr[0])
             | ((i_hsize == 2'd2) & (|i_haddr[1:0]));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    unique case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        state_d = ST_IDLE;
        if (acc) begin
          addr_d  = i_haddr[AW+1:0];
          write_d = i_hwrite;
          size_d  = i_hsize;
          cnt_d   = WS_LD;
          if (bad)
            state_d = ST_ERR1;
          else if (WAIT_STATES > 0)
            state_d = ST_WAIT;
          else
            state_d = ST_DATA;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0)
          state_d = ST_DATA;
        else
          cnt_d = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    strb = 4'b0000;
    unique case (1'b1)
      size_q == 2'd0: strb = 4'b0001 << addr_q[1:0];
      size_q == 2'd1: strb = addr_q[1] ? 4'b1100 : 4'b0011;
      default:        strb = 4'b1111;
    endcase
  end

  assign we = (state_q == ST_DATA) & write_q;

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
    end
  end

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < 4; b++)
        if (strb[b])
          mem_q[idx][8*b +: 8] <= i_hwdata[8*b +: 8];
    end
  end

  assign o_hready = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
  assign o_hresp  = {1'b0, (state_q == ST_ERR1) || (state_q == ST_ERR2)};
  assign o_hrdata = ((state_q == ST_DATA) && !write_q) ? mem_q[idx] : '0;

endmodule

// File: tb/tb_ahb_slave_ram.sv
// Directed bench for ahb_slave_ram at WAIT_STATES 0, 2 and 3.
// Each instance has its own bus signals, indexed 0..2.
module tb_ahb_slave_ram;

  logic        clk = 1'b0;
  logic        rst_n    [3];
  logic        hsel     [3];
  logic [31:0] haddr    [3];
  logic [1:0]  htrans   [3];
  logic [1:0]  hsize    [3];
  logic [1:0]  hburst   [3];
  logic        hwrite   [3];
  logic [31:0] hwdata   [3];
  logic        block    [3];
  logic        hrdy_in  [3];
  logic        hready_o [3];
  logic [1:0]  hresp_o  [3];
  logic [31:0] hrdata_o [3];

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign hrdy_in[0] = hready_o[0] & ~block[0];
  assign hrdy_in[1] = hready_o[1] & ~block[1];
  assign hrdy_in[2] = hready_o[2] & ~block[2];

  ahb_slave_ram #(.WAIT_STATES(0)) u_ws0 (
    .i_hclk(clk), .i_hreset_n(rst_n[0]), .i_hsel(hsel[0]),
    .i_haddr(haddr[0]), .i_htrans(htrans[0]), .i_hsize(hsize[0]),
    .i_hburst(hburst[0]), .i_hwrite(hwrite[0]),
    .i_hwdata(hwdata[0]), .i_hready(hrdy_in[0]),
    .o_hready(hready_o[0]), .o_hresp(hresp_o[0]),
    .o_hrdata(hrdata_o[0])
  );

  ahb_slave_ram #(.WAIT_STATES(2)) u_ws2 (
    .i_hclk(clk), .i_hreset_n(rst_n[1]), .i_hsel(hsel[1]),
    .i_haddr(haddr[1]), .i_htrans(htrans[1]), .i_hsize(hsize[1]),
    .i_hburst(hburst[1]), .i_hwrite(hwrite[1]),
    .i_hwdata(hwdata[1]), .i_hready(hrdy_in[1]),
    .o_hready(hready_o[1]), .o_hresp(hresp_o[1]),
    .o_hrdata(hrdata_o[1])
  );

  ahb_slave_ram #(.WAIT_STATES(3)) u_ws3 (
    .i_hclk(clk), .i_hreset_n(rst_n[2]), .i_hsel(hsel[2]),
    .i_haddr(haddr[2]), .i_htrans(htrans[2]), .i_hsize(hsize[2]),
    .i_hburst(hburst[2]), .i_hwrite(hwrite[2]),
    .i_hwdata(hwdata[2]), .i_hready(hrdy_in[2]),
    .o_hready(hready_o[2]), .o_hresp(hresp_o[2]),
    .o_hrdata(hrdata_o[2])
  );

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic bus_idle(int k);
    hsel[k]   = 1'b0;
    htrans[k] = 2'd0;
  endtask

  task automatic addr_ph(int k, logic [31:0] a, logic [1:0] sz,
                         logic wr);
    hsel[k]   = 1'b1;
    htrans[k] = 2'd2;
    haddr[k]  = a;
    hsize[k]  = sz;
    hwrite[k] = wr;
  endtask

  task automatic xfer(int k, logic [31:0] a, logic [1:0] sz,
                      logic wr, logic [31:0] wd, int exp_w,
                      logic [31:0] exp_rd, string tag);
    int w = 0;
    addr_ph(k, a, sz, wr);
    step();
    bus_idle(k);
    hwdata[k] = wd;
    while (hready_o[k] == 1'b0 && w < 20) begin
      w++;
      step();
    end
    chk({tag, "_waits"}, w, exp_w);
    chk({tag, "_resp"}, {30'd0, hresp_o[k]}, 32'd0);
    if (!wr)
      chk({tag, "_rdata"}, hrdata_o[k], exp_rd);
    step();
  endtask

  task automatic err(int k, logic [31:0] a, logic [1:0] sz,
                     logic wr, string tag);
    addr_ph(k, a, sz, wr);
    step();
    bus_idle(k);
    hwdata[k] = 32'hFFFF_FFFF;
    chk({tag, "_e1_rdy"}, {31'd0, hready_o[k]}, 32'd0);
    chk({tag, "_e1_resp"}, {30'd0, hresp_o[k]}, 32'd1);
    chk({tag, "_e1_rd"}, hrdata_o[k], 32'd0);
    step();
    chk({tag, "_e2_rdy"}, {31'd0, hready_o[k]}, 32'd1);
    chk({tag, "_e2_resp"}, {30'd0, hresp_o[k]}, 32'd1);
    chk({tag, "_e2_rd"}, hrdata_o[k], 32'd0);
    step();
    chk({tag, "_idle_rdy"}, {31'd0, hready_o[k]}, 32'd1);
    chk({tag, "_idle_resp"}, {30'd0, hresp_o[k]}, 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; hsel[k] = 1'b0; haddr[k] = '0;
      htrans[k] = '0; hsize[k] = '0; hburst[k] = '0;
      hwrite[k] = 1'b0; hwdata[k] = '0; block[k] = 1'b0;
    end
    repeat (2) step();
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_rdy%0d", k), {31'd0, hready_o[k]}, 32'd1);
      chk($sformatf("rst_resp%0d", k), {30'd0, hresp_o[k]}, 32'd0);
      chk($sformatf("rst_rd%0d", k), hrdata_o[k], 32'd0);
    end

    // back-to-back word write then read, zero wait states
    addr_ph(0, 32'h10, 2'd2, 1'b1);
    step();
    chk("t1_wdata_rdy", {31'd0, hready_o[0]}, 32'd1);
    chk("t1_wdata_rd", hrdata_o[0], 32'd0);
    hwdata[0] = 32'hDEAD_BEEF;
    addr_ph(0, 32'h10, 2'd2, 1'b0);
    step();
    bus_idle(0);
    chk("t1_rdata_rdy", {31'd0, hready_o[0]}, 32'd1);
    chk("t1_rdata_resp", {30'd0, hresp_o[0]}, 32'd0);
    chk("t1_rdata", hrdata_o[0], 32'hDEAD_BEEF);
    step();
    chk("t1_idle_rd", hrdata_o[0], 32'd0);

    xfer(0, 32'h12, 2'd1, 1'b1, 32'hCAFE_0000, 0, 0, "t1_hw");
    xfer(0, 32'h10, 2'd2, 1'b0, 0, 0, 32'hCAFE_BEEF, "t1_hr");
    xfer(0, 32'hFC, 2'd2, 1'b1, 32'h0BAD_F00D, 0, 0, "t1_topw");
    xfer(0, 32'hFC, 2'd2, 1'b0, 0, 0, 32'h0BAD_F00D, "t1_topr");

    // two wait states, byte merge
    xfer(1, 32'h10, 2'd2, 1'b1, 32'hDEAD_BEEF, 2, 0, "t2_ww");
    xfer(1, 32'h11, 2'd0, 1'b1, 32'h0000_AB00, 2, 0, "t2_wb");
    xfer(1, 32'h10, 2'd2, 1'b0, 0, 2, 32'hDEAD_ABEF, "t2_rd");

    // illegal transfers
    err(0, 32'h2000_0000, 2'd2, 1'b1, "t3_oor");
    err(0, 32'h0000_0100, 2'd2, 1'b1, "t3_edge");
    xfer(0, 32'h00, 2'd2, 1'b0, 0, 0, 32'd0, "t3_ram0");
    xfer(0, 32'h10, 2'd2, 1'b0, 0, 0, 32'hCAFE_BEEF, "t3_ram10");
    err(0, 32'h13, 2'd1, 1'b0, "t4_half");
    err(0, 32'h00, 2'd3, 1'b0, "t4_sz3");
    err(0, 32'h12, 2'd2, 1'b0, "t4_word");

    // no accept: BUSY, and NONSEQ with bus hready low
    hsel[0] = 1'b1; htrans[0] = 2'd1; haddr[0] = 32'h0;
    hsize[0] = 2'd2; hwrite[0] = 1'b1; hwdata[0] = 32'h5555_5555;
    step();
    chk("t5_busy_rdy", {31'd0, hready_o[0]}, 32'd1);
    chk("t5_busy_resp", {30'd0, hresp_o[0]}, 32'd0);
    htrans[0] = 2'd2;
    block[0] = 1'b1;
    step();
    chk("t5_blk_rdy", {31'd0, hready_o[0]}, 32'd1);
    bus_idle(0);
    block[0] = 1'b0;
    step();
    chk("t5_blk_rdy2", {31'd0, hready_o[0]}, 32'd1);
    xfer(0, 32'h00, 2'd2, 1'b0, 0, 0, 32'd0, "t5_ram0");

    // reset during a wait state drops the write
    addr_ph(2, 32'h20, 2'd2, 1'b1);
    step();
    bus_idle(2);
    hwdata[2] = 32'h1234_5678;
    chk("t6_w1_rdy", {31'd0, hready_o[2]}, 32'd0);
    step();
    chk("t6_w2_rdy", {31'd0, hready_o[2]}, 32'd0);
    rst_n[2] = 1'b0;
    #1;
    chk("t6_rst_rdy", {31'd0, hready_o[2]}, 32'd1);
    chk("t6_rst_resp", {30'd0, hresp_o[2]}, 32'd0);
    chk("t6_rst_rd", hrdata_o[2], 32'd0);
    step();
    step();
    rst_n[2] = 1'b1;
    step();
    xfer(2, 32'h20, 2'd2, 1'b0, 0, 3, 32'd0, "t6_rd");
    xfer(2, 32'h24, 2'd2, 1'b1, 32'hA5A5_5A5A, 3, 0, "t6_w2");
    xfer(2, 32'h24, 2'd2, 1'b0, 0, 3, 32'hA5A5_5A5A, "t6_r2");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
